// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, control literals and the fetch-buffer entry type
// for the instruction fetch unit.
package if_fetch_unit_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0] ZeroWord = 32'h0000_0000;

  localparam logic RstEnable   = 1'b1;
  localparam logic RstDisable  = 1'b0;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } fetch_entry_t;

  function automatic logic [InstAddrBus-1:0] word_align(
    input logic [InstAddrBus-1:0] a
  );
    return {a[InstAddrBus-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// Two-entry {pc,inst} buffer; entry 0 is always the head.
// Flush empties it; push and pop in the same cycle keep the count.
module fetch_fifo
  import if_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t din_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t e0_q, e0_d;
  fetch_entry_t e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    unique case (1'b1)
      flush_i: cnt_d = 2'd0;
      (push_i && pop_i): begin
        if (cnt_q == 2'd2) begin
          e0_d = e1_q;
          e1_d = din_i;
        end else begin
          e0_d = din_i;
        end
      end
      (push_i && !pop_i): begin
        if (cnt_q == 2'd0) e0_d = din_i;
        else               e1_d = din_i;
        cnt_d = cnt_q + 2'd1;
      end
      (pop_i && !push_i): begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      e0_q  <= '{pc: ZeroWord, inst: ZeroWord};
      e1_q  <= '{pc: ZeroWord, inst: ZeroWord};
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign head_o  = e0_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: credit-limited ROM requests feeding a
// 2-entry buffer, with redirect flush and valid/ready delivery.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   rom_ce_o,
  output logic [InstAddrBus-1:0] rom_addr_o,
  input  logic [InstBus-1:0]     rom_data_i,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_addr_i,
  output logic                   id_valid_o,
  input  logic                   id_ready_i,
  output logic [InstAddrBus-1:0] id_pc_o,
  output logic [InstBus-1:0]     id_inst_o
);

  if (DEPTH != 2) begin : g_bad_depth
    $error("if_fetch_unit: only DEPTH=2 is supported");
  end

  logic [InstAddrBus-1:0] pc_q, pc_d;
  logic [InstAddrBus-1:0] req_pc_q;
  logic                   inflight_q;
  logic                   kill_q;

  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t din;
  logic [2:0]   credit;
  logic         pop;
  logic         push;
  logic [1:0]   unused_tgt_lsb;

  assign unused_tgt_lsb = branch_target_addr_i[1:0];

  assign pop    = id_valid_o & id_ready_i;
  assign credit = {1'b0, count}
                + {2'b00, inflight_q}
                - {2'b00, pop};

  // Only request when the buffer can absorb every outstanding response.
  always_comb begin
    rom_ce_o = ChipDisable;
    if (rst == RstDisable && !branch_flag_i && credit < 3'd2)
      rom_ce_o = ChipEnable;
  end

  assign push = inflight_q & ~kill_q & ~branch_flag_i;
  assign din  = '{pc: req_pc_q, inst: rom_data_i};

  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      branch_flag_i: pc_d = word_align(branch_target_addr_i);
      (!branch_flag_i && rom_ce_o): pc_d = pc_q + 32'd4;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= ZeroWord;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= rom_ce_o;
      kill_q     <= branch_flag_i;
      if (rom_ce_o) req_pc_q <= pc_q;
    end
  end

  fetch_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop & ~branch_flag_i),
    .flush_i (branch_flag_i),
    .din_i   (din),
    .count_o (count),
    .head_o  (head)
  );

  assign rom_addr_o = pc_q;
  assign id_valid_o = (count != 2'd0);
  assign id_pc_o    = head.pc;
  assign id_inst_o  = head.inst;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit against a stream-level model:
// sequential request/delivery addresses, capacity, latency, stability.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data = 32'h0;
  logic        branch = 1'b0;
  logic [31:0] tgt = 32'h0;
  logic        valid;
  logic        rdy = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_del  = RST_PC;
  logic [31:0] exp_req  = RST_PC;
  int          outst    = 0;
  int          quiet    = 0;
  bit          prev_rst = 1'b0;
  bit          held     = 1'b0;
  logic [31:0] held_pc  = 32'h0;
  logic [31:0] held_ins = 32'h0;

  always #5 clk = ~clk;

  always_ff @(posedge clk)
    rom_data <= rom_ce ? (32'hA000_0000 | rom_addr) : 32'hDEAD_BEEF;

  if_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .rom_ce_o             (rom_ce),
    .rom_addr_o           (rom_addr),
    .rom_data_i           (rom_data),
    .branch_flag_i        (branch),
    .branch_target_addr_i (tgt),
    .id_valid_o           (valid),
    .id_ready_i           (rdy),
    .id_pc_o              (id_pc),
    .id_inst_o            (id_inst)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit b,
                       input logic [31:0] t, input bit rd);
    @(posedge clk);
    #1;
    rst = r; branch = b; tgt = t; rdy = rd;
    #1;
    if (prev_rst) begin
      chk("rst_valid", {31'b0, valid}, 32'h0);
      chk("rst_pc", id_pc, 32'h0);
      chk("rst_inst", id_inst, 32'h0);
    end
    if (held) begin
      chk("hold_valid", {31'b0, valid}, 32'h1);
      chk("hold_pc", id_pc, held_pc);
      chk("hold_inst", id_inst, held_ins);
    end
    held = 1'b0;
    if (r) begin
      chk("rst_ce", {31'b0, rom_ce}, 32'h0);
      exp_del = RST_PC;
      exp_req = RST_PC;
      outst   = 0;
      quiet   = 0;
    end else begin
      quiet++;
      if (quiet <= 2) chk("lat_valid", {31'b0, valid}, 32'h0);
      else            chk("stream_valid", {31'b0, valid}, 32'h1);
      if (valid && rd) begin
        chk("del_pc", id_pc, exp_del);
        chk("del_inst", id_inst, 32'hA000_0000 | exp_del);
        exp_del += 32'd4;
        outst--;
      end
      if (b) begin
        chk("br_ce", {31'b0, rom_ce}, 32'h0);
        exp_del = {t[31:2], 2'b00};
        exp_req = {t[31:2], 2'b00};
        outst   = 0;
        quiet   = 0;
      end else begin
        if (quiet == 1) chk("first_req", {31'b0, rom_ce}, 32'h1);
        if (rom_ce) begin
          chk("req_addr", rom_addr, exp_req);
          exp_req += 32'd4;
          outst++;
          chk("capacity", {31'b0, outst <= 2}, 32'h1);
        end
        if (valid && !rd) begin
          held     = 1'b1;
          held_pc  = id_pc;
          held_ins = id_inst;
        end
      end
    end
    prev_rst = r;
  endtask

  initial begin
    logic [31:0] t;
    bit          r, b, rd;
    int          ph;

    repeat (3) cycle(1, 0, 0, 1);
    repeat (10) cycle(0, 0, 0, 1);
    repeat (6) cycle(0, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 1);
    repeat (4) cycle(0, 0, 0, 0);
    cycle(0, 1, 32'h0000_0102, 0);
    repeat (5) cycle(0, 0, 0, 1);
    cycle(0, 1, 32'h0000_0040, 1);
    cycle(0, 1, 32'h0000_0080, 1);
    repeat (6) cycle(0, 0, 0, 1);
    repeat (4) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (5) cycle(0, 0, 0, 1);
    cycle(0, 1, 32'hFFFF_FFF8, 1);
    repeat (6) cycle(0, 0, 0, 1);

    for (int i = 0; i < 2500; i++) begin
      ph = i / 500;
      r  = ($urandom_range(0, 99) == 0);
      b  = (ph >= 2) ? ($urandom_range(0, 9) == 0)
                     : ($urandom_range(0, 39) == 0);
      rd = (ph == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (ph == 4 && (i % 20) < 6) rd = 1'b0;
      t  = ($urandom_range(0, 3) == 0)
         ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
         : 32'($urandom);
      cycle(r, b, t, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
